// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor: computes a - b - borrow_in K bits per cycle, LSB digit first,
// with a valid/ready handshake on both the operand and the result side.
module serial_borrow_subtractor #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int SAFE_K = (K < 1) ? 1 : K;
    localparam int DIGITS = N / SAFE_K;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    generate
        if (K < 1 || (N % SAFE_K) != 0) begin : g_bad_params
            $error("serial_borrow_subtractor: K must be >= 1 and divide N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [N-1:0]    a_q, b_q, res_q, res_next;
    logic            borrow_q;
    logic [CW-1:0]   cnt;
    logic [K-1:0]    a_dig, b_dig, diff;
    logic            bw;
    logic            is_last;
    int              lo;

    // Digit slice for the current counter value; the K+1-bit difference's top bit is the borrow.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lo          = int'(cnt) * K;
        a_dig       = a_q[lo +: K];
        b_dig       = b_q[lo +: K];
        {bw, diff}  = {1'b0, a_dig} - {1'b0, b_dig} - {{K{1'b0}}, borrow_q};
        res_next    = res_q;
        res_next[lo +: K] = diff;
        is_last     = (cnt == LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (is_last)   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Published outputs load only on the final digit, so they hold their value outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            res_q      <= '0;
            d          <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= borrow_in;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    res_q    <= res_next;
                    borrow_q <= bw;
                    if (is_last) begin
                        d          <= res_next;
                        borrow_out <= bw;
                        overflow   <= (a_q[N-1] != b_q[N-1]) && (res_next[N-1] != a_q[N-1]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
